// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// FETCH_MISALIGN_CHECK_EN adds the HALT state used after a misaligned redirect.
package fetch_pkg;

  localparam int          FETCH_XLEN           = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR              = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP
`ifdef FETCH_MISALIGN_CHECK_EN
    , S_HALT
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural fetch PC register: async active-low reset to RESET_VECTOR,
// loads d when load is high.
module fetch_pc_reg #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= RESET_VECTOR;
    else if (load) q <= d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle RV32 fetch controller: one outstanding imem request, valid/ready to decode,
// redirect with wrong-path discard. FETCH_MISALIGN_CHECK_EN enables misaligned-redirect trap.
//
// state  | meaning
// IDLE   | first cycle after reset, request issues next cycle
// REQ    | imem_req_valid high at pc, waiting for imem_req_ready
// WAIT   | request accepted, waiting for the response
// OUT    | buffered instruction presented to decode
// DROP   | wrong-path response still owed by memory, discard it
// HALT   | misaligned redirect seen, frozen until reset (check build only)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN         = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_exc,
  output logic [XLEN-1:0] exc_addr
);

  fetch_state_e    state;
  logic            req_q;
  logic            ifv_q;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            pc_load;
  logic            redirect_take;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign;
  logic            exc_q;
  logic [XLEN-1:0] exc_addr_q;

  assign misalign      = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state != S_HALT);
  assign redirect_take = redirect_valid && (redirect_pc[1:0] == 2'b00) && (state != S_HALT);
  assign fetch_exc     = exc_q;
  assign exc_addr      = exc_addr_q;
`else
  assign redirect_take = redirect_valid;
  assign fetch_exc     = 1'b0;
  assign exc_addr      = '0;
`endif

  // Redirect wins over the sequential advance, including an OUT handshake in the same cycle.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc + PC_INCR;
    if (redirect_take) begin
      pc_load = 1'b1;
      pc_next = redirect_pc & ~XLEN'(3);
    end else if (state == S_OUT && if_ready) begin
      pc_load = 1'b1;
    end
  end

  fetch_pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pc_load),
    .d       (pc_next),
    .q       (pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      ifv_q     <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_CHECK_EN
      exc_q <= 1'b0;
      if (misalign) begin
        state      <= S_HALT;
        req_q      <= 1'b0;
        ifv_q      <= 1'b0;
        exc_q      <= 1'b1;
        exc_addr_q <= redirect_pc;
      end else
`endif
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            state <= redirect_take ? S_DROP : S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect_take) begin
            state <= imem_rsp_valid ? S_REQ : S_DROP;
            req_q <= imem_rsp_valid;
          end else if (imem_rsp_valid) begin
            state     <= S_OUT;
            ifv_q     <= 1'b1;
            buf_pc    <= pc;
            buf_instr <= imem_rsp_data;
          end
        end
        S_OUT: begin
          if (redirect_take || if_ready) begin
            state <= S_REQ;
            ifv_q <= 1'b0;
            req_q <= 1'b1;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid && !redirect_take) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid = req_q;
  assign imem_req_addr  = pc;
  assign if_valid       = ifv_q;
  assign if_pc          = buf_pc;
  assign if_instr       = buf_instr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus hand sequences for
// mid-run reset, redirect from IDLE and the misaligned redirect.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_exc;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_exc      (fetch_exc),
    .exc_addr       (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] data;
    logic        ifr;
    logic        redir;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] data,
                              input logic ifr, input logic redir, input logic [31:0] rpc,
                              input logic e_rv, input logic [31:0] e_addr,
                              input logic e_ifv, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.data = data; v.ifr = ifr; v.redir = redir; v.rpc = rpc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] data,
                       input logic ifr, input logic redir, input logic [31:0] rpc);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = data;
    if_ready       = ifr;
    redirect_valid = redir;
    redirect_pc    = rpc;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, " if_valid"},  {31'd0, if_valid},       32'd0);
    chk({tag, " fetch_exc"}, {31'd0, fetch_exc},      32'd0);
    chk({tag, " exc_addr"},  exc_addr,                32'd0);
    chk({tag, " if_pc"},     if_pc,                   32'd0);
    chk({tag, " if_instr"},  if_instr,                32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    reset_n = 1'b0;

    //         rdy rsp data          ifr red rpc           rv  addr          ifv pc            instr
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h13,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h13));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h00100093,  0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         32'h00100093));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         32'h00100093));
    tbl.push_back(mk(1, 1, 32'h00000BAD,  0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         32'h00100093));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         32'h00100093));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h4,         32'h00100093));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h4,         32'h00100093));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 32'h100,       0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'hDEADBEEF,  0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h11,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 1, 32'h200,       0, 32'h0,         1, 32'h100,       32'h11));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h22,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'h200,       32'h22));
    tbl.push_back(mk(0, 0, 32'h0,         0, 1, 32'h300,       1, 32'h204,       0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 1, 32'h400,       1, 32'h300,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h66,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h400,       0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h77,        0, 1, 32'hFFFFFFFC,  0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 1, 32'h33,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFFFFFC,  32'h33));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0));

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;

    // Row k describes cycle k+1 after reset release: outputs seen, inputs driven.
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("row%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rv});
      chk($sformatf("row%0d if_valid", i),  {31'd0, if_valid},       {31'd0, tbl[i].e_ifv});
      chk($sformatf("row%0d fetch_exc", i), {31'd0, fetch_exc},      32'd0);
      if (tbl[i].e_rv)
        chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
      if (tbl[i].e_ifv) begin
        chk($sformatf("row%0d if_pc", i),    if_pc,    tbl[i].e_pc);
        chk($sformatf("row%0d if_instr", i), if_instr, tbl[i].e_instr);
      end
      drive(tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].ifr, tbl[i].redir, tbl[i].rpc);
      @(negedge clk);
    end

    // Mid-run reset acts immediately, away from any clock edge.
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(negedge clk);

    // Stray response across release is ignored; redirect taken from IDLE.
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 32'hCAFE0000, 1'b0, 1'b1, 32'h40);
    chk("idle req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("idle_redir req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("idle_redir req_addr",  imem_req_addr,           32'h40);
    drive(1'b0, 1'b1, 32'hCAFE0001, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("stray_rsp req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("stray_rsp if_valid",  {31'd0, if_valid},       32'd0);
    chk("stray_rsp req_addr",  imem_req_addr,           32'h40);

    // Misaligned redirect from REQ.
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h102);
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign fetch_exc", {31'd0, fetch_exc},      32'd1);
    chk("misalign exc_addr",  exc_addr,                32'h102);
    chk("misalign req_valid", {31'd0, imem_req_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h99, 1'b1, 1'b1, 32'h500);
      @(negedge clk);
      chk($sformatf("halt%0d fetch_exc", k), {31'd0, fetch_exc},      32'd0);
      chk($sformatf("halt%0d req_valid", k), {31'd0, imem_req_valid}, 32'd0);
      chk($sformatf("halt%0d if_valid", k),  {31'd0, if_valid},       32'd0);
      chk($sformatf("halt%0d exc_addr", k),  exc_addr,                32'h102);
    end
`else
    chk("misalign fetch_exc", {31'd0, fetch_exc},      32'd0);
    chk("misalign exc_addr",  exc_addr,                32'd0);
    chk("misalign req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("misalign req_addr",  imem_req_addr,           32'h100);
`endif
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
